// File: rtl/tipi_msg_sequencer.sv
// tipi_msg_sequencer: r_clk-domain controller for the TIPI message channel.
// It runs the TC/RC handshake for the Raspberry Pi, turns TD into a
// valid/ready byte stream, and turns a valid/ready stream into RD.
// It follows the 2-byte length + payload framing of transmitted messages
// so that the final byte of each message can be flagged on tx_last.
// Optional feature macro: TIPI_EXTINT_EN (drives ti_extint_n when the Pi has
// data waiting while the channel is idle). Without it, ti_extint_n is tied to 1.
// Byte vectors use TI bit order [0:7]; bit 0 is the MSB, bit 7 is the LSB.
module tipi_msg_sequencer #(
    parameter logic [0:7] SYNC_CODE = 8'hF1,
    parameter logic [0:7] TX_CODE   = 8'h02,
    parameter logic [0:7] RX_CODE   = 8'h06
) (
    input  logic       r_clk,
    input  logic       r_rst,
    input  logic [0:7] tc,
    input  logic [0:7] td,
    output logic [0:7] rc,
    output logic [0:7] rd,
    output logic [0:7] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       tx_last,
    input  logic [0:7] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    output logic       busy,
    output logic       proto_err,
    output logic       ti_extint_n
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TX_WAIT = 2'd1,
        RX_WAIT = 2'd2,
        ACK     = 2'd3
    } state_t;

    // Framing phases: expecting length MSB, length LSB, or payload.
    localparam logic [1:0] PH_MSB = 2'd0;
    localparam logic [1:0] PH_LSB = 2'd1;
    localparam logic [1:0] PH_PAY = 2'd2;

    state_t      state_reg, state_next;
    logic [0:7]  s1_reg, s2_reg;
    logic [0:7]  last_tc_reg, last_tc_next;
    logic        rec_reg, rec_next;           // a new code was recognised last cycle
    logic [0:7]  rc_reg, rc_next;
    logic [0:7]  rd_reg, rd_next;
    logic [0:7]  tx_data_reg, tx_data_next;
    logic        tx_valid_reg, tx_valid_next;
    logic        rx_ready_reg, rx_ready_next;
    logic        proto_err_reg, proto_err_next;
    logic [1:0]  phase_reg, phase_next;
    logic [15:0] remaining_reg, remaining_next;
    logic [0:7]  len_msb_reg, len_msb_next;

    logic        new_code;
    logic [15:0] len_word;
    logic        is_sync, is_tx, is_rx;

    // Recognition is only armed in IDLE with no decode pending, so codes
    // arriving mid-transfer simply wait in the synchronizer.
    assign new_code = (state_reg == IDLE) && !rec_reg &&
                      (s2_reg == s1_reg) && (s2_reg != last_tc_reg);

    // Bit 7 of the TX/RX codes toggles per byte, so only bits [0:6] are compared.
    assign is_sync = (last_tc_reg == SYNC_CODE);
    assign is_tx   = (last_tc_reg[0:6] == TX_CODE[0:6]);
    assign is_rx   = (last_tc_reg[0:6] == RX_CODE[0:6]);

    assign len_word = {len_msb_reg, tx_data_reg};

    // Two-flop synchronizer for the asynchronous TC latch.
    always_ff @(posedge r_clk) begin
        if (r_rst) begin
            s1_reg <= 8'h00;
            s2_reg <= 8'h00;
        end else begin
            s1_reg <= tc;
            s2_reg <= s1_reg;
        end
    end

    // State, datapath and framing registers.
    always_ff @(posedge r_clk) begin
        if (r_rst) begin
            state_reg     <= IDLE;
            last_tc_reg   <= 8'h00;
            rec_reg       <= 1'b0;
            rc_reg        <= 8'h00;
            rd_reg        <= 8'h00;
            tx_data_reg   <= 8'h00;
            tx_valid_reg  <= 1'b0;
            rx_ready_reg  <= 1'b0;
            proto_err_reg <= 1'b0;
            phase_reg     <= PH_MSB;
            remaining_reg <= 16'd0;
            len_msb_reg   <= 8'h00;
        end else begin
            state_reg     <= state_next;
            last_tc_reg   <= last_tc_next;
            rec_reg       <= rec_next;
            rc_reg        <= rc_next;
            rd_reg        <= rd_next;
            tx_data_reg   <= tx_data_next;
            tx_valid_reg  <= tx_valid_next;
            rx_ready_reg  <= rx_ready_next;
            proto_err_reg <= proto_err_next;
            phase_reg     <= phase_next;
            remaining_reg <= remaining_next;
            len_msb_reg   <= len_msb_next;
        end
    end

    // Next-state logic: code decode, stream handshakes, RC echo and framing.
    always_comb begin
        state_next     = state_reg;
        last_tc_next   = last_tc_reg;
        rec_next       = 1'b0;
        rc_next        = rc_reg;
        rd_next        = rd_reg;
        tx_data_next   = tx_data_reg;
        tx_valid_next  = tx_valid_reg;
        rx_ready_next  = rx_ready_reg;
        proto_err_next = 1'b0;
        phase_next     = phase_reg;
        remaining_next = remaining_reg;
        len_msb_next   = len_msb_reg;

        if (new_code) begin
            last_tc_next = s2_reg;
            rec_next     = 1'b1;
        end

        case (state_reg)
            IDLE: begin
                if (rec_reg) begin
                    if (is_sync) begin
                        phase_next     = PH_MSB;
                        remaining_next = 16'd0;
                        rc_next        = SYNC_CODE;
                    end else if (is_tx) begin
                        tx_data_next  = td;
                        tx_valid_next = 1'b1;
                        state_next    = TX_WAIT;
                    end else if (is_rx) begin
                        // Receiving mid-message abandons the partial message.
                        if (phase_reg != PH_MSB) begin
                            proto_err_next = 1'b1;
                            phase_next     = PH_MSB;
                        end
                        rx_ready_next = 1'b1;
                        state_next    = RX_WAIT;
                    end else begin
                        proto_err_next = 1'b1;
                    end
                end
            end
            TX_WAIT: begin
                if (tx_ready) begin
                    tx_valid_next = 1'b0;
                    state_next    = ACK;
                    case (phase_reg)
                        PH_MSB: begin
                            len_msb_next = tx_data_reg;
                            phase_next   = PH_LSB;
                        end
                        PH_LSB: begin
                            remaining_next = len_word;
                            phase_next     = (len_word == 16'd0) ? PH_MSB : PH_PAY;
                        end
                        PH_PAY: begin
                            if (remaining_reg != 16'd0) begin
                                remaining_next = remaining_reg - 16'd1;
                            end
                            if (remaining_reg <= 16'd1) begin
                                phase_next = PH_MSB;
                            end
                        end
                        default: phase_next = PH_MSB;
                    endcase
                end
            end
            RX_WAIT: begin
                if (rx_valid) begin
                    rd_next       = rx_data;
                    rx_ready_next = 1'b0;
                    state_next    = ACK;
                end
            end
            ACK: begin
                rc_next    = last_tc_reg;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef TIPI_EXTINT_EN
    logic extint_n_reg, extint_n_next;

    // Interrupt request: set when the Pi has data for an idle channel,
    // released as soon as the TI issues its next code.
    always_comb begin
        extint_n_next = extint_n_reg;
        if (new_code) begin
            extint_n_next = 1'b1;
        end else if (rx_valid && (state_reg == IDLE) && (phase_reg == PH_MSB)) begin
            extint_n_next = 1'b0;
        end
    end

    // Interrupt request register.
    always_ff @(posedge r_clk) begin
        if (r_rst) begin
            extint_n_reg <= 1'b1;
        end else begin
            extint_n_reg <= extint_n_next;
        end
    end

    assign ti_extint_n = extint_n_reg;
`else
    assign ti_extint_n = 1'b1;
`endif

    assign rc        = rc_reg;
    assign rd        = rd_reg;
    assign tx_data   = tx_data_reg;
    assign tx_valid  = tx_valid_reg;
    assign rx_ready  = rx_ready_reg;
    assign proto_err = proto_err_reg;
    assign busy      = (state_reg != IDLE);
    assign tx_last   = tx_valid_reg &&
                       (((phase_reg == PH_LSB) && (len_word == 16'd0)) ||
                        ((phase_reg == PH_PAY) && (remaining_reg == 16'd1)));

endmodule

// File: tb/tb_tipi_msg_sequencer.sv
// tb_tipi_msg_sequencer: randomized bench for tipi_msg_sequencer.
// The reference model tracks the TI's view of the channel: the last code
// written, the expected RC, and the byte position within the current message.
module tb_tipi_msg_sequencer;

    logic       r_clk = 1'b0;
    logic       r_rst;
    logic [0:7] tc, td, rc, rd, tx_data, rx_data;
    logic       tx_valid, tx_ready, tx_last, rx_valid, rx_ready;
    logic       busy, proto_err, ti_extint_n;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [7:0] m_last;   // last code the TI wrote to TC
    logic [7:0] m_rc;     // value RC must hold
    int         m_pos;    // bytes already sent in the current message
    int         m_len;    // payload length of the current message
    logic [7:0] m_msb;

    tipi_msg_sequencer dut (
        .r_clk(r_clk), .r_rst(r_rst), .tc(tc), .td(td), .rc(rc), .rd(rd),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_last(tx_last), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .busy(busy), .proto_err(proto_err),
        .ti_extint_n(ti_extint_n)
    );

    always #5 r_clk = ~r_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Send one byte through TD/TC and accept it on the stream side.
    task automatic tx_byte(input logic [7:0] b);
        logic [7:0] code;
        logic       exp_last;
        int         d;
        // Model: work out the byte's role from its position in the message.
        if (m_pos == 0) begin
            exp_last = 1'b0;
            m_msb    = b;
            m_pos    = 1;
        end else if (m_pos == 1) begin
            m_len    = int'({m_msb, b});
            exp_last = (m_len == 0);
            m_pos    = exp_last ? 0 : 2;
        end else begin
            exp_last = ((m_pos - 1) == m_len);
            m_pos    = exp_last ? 0 : m_pos + 1;
        end
        code = (m_last == 8'h02) ? 8'h03 : 8'h02;
        td = b;
        tc = code;
        repeat (3) @(negedge r_clk);
        check("tx_valid_early", tx_valid, 1'b0);
        @(negedge r_clk);
        check("tx_valid_rise", tx_valid, 1'b1);
        check("tx_data", tx_data, b);
        check("tx_last", tx_last, exp_last);
        check("tx_busy", busy, 1'b1);
        check("tx_proto_err", proto_err, 1'b0);
        d = $urandom_range(0, 3);
        repeat (d) @(negedge r_clk);
        check("tx_hold", {tx_valid, tx_data}, {1'b1, b});
        tx_ready = 1'b1;
        @(negedge r_clk);
        tx_ready = 1'b0;
        check("tx_valid_drop", tx_valid, 1'b0);
        check("tx_rc_before", rc, m_rc);
        @(negedge r_clk);
        m_last = code;
        m_rc   = code;
        check("tx_rc_echo", rc, m_rc);
        check("tx_idle", busy, 1'b0);
        $display("TX byte %02h code %02h last=%0d rc=%02h", b, code, exp_last, rc);
    endtask

    // Receive one byte from the stream side into RD.
    task automatic rx_byte(input logic [7:0] v, input int delay);
        logic [7:0] code;
        logic       exp_err;
        exp_err = (m_pos != 0);
        m_pos   = 0;
        code = (m_last == 8'h06) ? 8'h07 : 8'h06;
        tc = code;
        repeat (3) @(negedge r_clk);
        check("rx_ready_early", rx_ready, 1'b0);
        @(negedge r_clk);
        check("rx_ready_rise", rx_ready, 1'b1);
        check("rx_proto_err", proto_err, exp_err);
        check("rx_extint_rel", ti_extint_n, 1'b1);
        @(negedge r_clk);
        check("rx_err_pulse", proto_err, 1'b0);
        repeat (delay) @(negedge r_clk);
        check("rx_ready_hold", rx_ready, 1'b1);
        rx_data  = v;
        rx_valid = 1'b1;
        @(negedge r_clk);
        rx_valid = 1'b0;
        check("rx_rd", rd, v);
        check("rx_ready_drop", rx_ready, 1'b0);
        check("rx_rc_before", rc, m_rc);
        @(negedge r_clk);
        m_last = code;
        m_rc   = code;
        check("rx_rc_echo", rc, m_rc);
        $display("RX byte %02h code %02h err=%0d rc=%02h", v, code, exp_err, rc);
    endtask

    // SYNC code: RC echoes it one cycle after recognition; framing restarts.
    task automatic do_sync();
        if (m_last == 8'hF1) return;
        tc = 8'hF1;
        repeat (3) @(negedge r_clk);
        check("sync_rc_early", rc, m_rc);
        @(negedge r_clk);
        m_last = 8'hF1;
        m_rc   = 8'hF1;
        m_pos  = 0;
        check("sync_rc", rc, 8'hF1);
        check("sync_busy", busy, 1'b0);
        $display("SYNC rc=%02h", rc);
    endtask

    // Unknown code: one proto_err pulse, RC untouched, stays idle.
    task automatic bad_code(input logic [7:0] c);
        tc = c;
        repeat (3) @(negedge r_clk);
        check("bad_err_early", proto_err, 1'b0);
        @(negedge r_clk);
        check("bad_err", proto_err, 1'b1);
        check("bad_rc", rc, m_rc);
        check("bad_busy", busy, 1'b0);
        @(negedge r_clk);
        check("bad_err_pulse", proto_err, 1'b0);
        m_last = c;
        $display("BAD code %02h err pulse rc=%02h", c, rc);
    endtask

    task automatic send_msg(input int len, input int stop_after);
        int n;
        n = 0;
        tx_byte(8'(len >> 8));
        n++;
        if (n < stop_after) tx_byte(8'(len));
        n++;
        for (int i = 0; i < len && n < stop_after; i++) begin
            tx_byte(8'($urandom));
            n++;
        end
    endtask

    initial begin
        int op;
        logic [7:0] c;
        r_rst = 1'b1; tc = 8'h00; td = 8'h00; tx_ready = 1'b0;
        rx_data = 8'h00; rx_valid = 1'b0;
        m_last = 8'h00; m_rc = 8'h00; m_pos = 0; m_len = 0; m_msb = 8'h00;
        repeat (3) @(negedge r_clk);
        r_rst = 1'b0;
        check("rst_rc", rc, 8'h00);
        check("rst_rd", rd, 8'h00);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_strobes", {tx_valid, rx_ready, tx_last, busy, proto_err}, 5'b0);
        check("rst_extint", ti_extint_n, 1'b1);

        // Directed: sync, 3-byte message, zero-length message
        do_sync();
        tx_byte(8'h00); tx_byte(8'h03); tx_byte(8'h41); tx_byte(8'h42); tx_byte(8'h43);
        tx_byte(8'h00); tx_byte(8'h00);
        rx_byte(8'h5A, 10);
        bad_code(8'h55);
        tx_byte(8'h00);          // length MSB only, then receive
        rx_byte(8'hC3, 1);
        tx_byte(8'h00); tx_byte(8'h00);   // framing restarted cleanly

        // Reset in the middle of TX_WAIT
        tc = (m_last == 8'h02) ? 8'h03 : 8'h02;
        td = 8'h99;
        repeat (4) @(negedge r_clk);
        check("mid_tx_valid", tx_valid, 1'b1);
        r_rst = 1'b1;
        tc = 8'h00;
        @(negedge r_clk);
        check("mrst_tx_valid", tx_valid, 1'b0);
        check("mrst_rc_rd", {rc, rd}, 16'h0000);
        check("mrst_tx_data", tx_data, 8'h00);
        check("mrst_busy", busy, 1'b0);
        r_rst = 1'b0;
        m_last = 8'h00; m_rc = 8'h00; m_pos = 0;
        repeat (6) @(negedge r_clk);
        check("post_rst_quiet", {tx_valid, rx_ready, busy}, 3'b000);
        $display("RESET mid TX_WAIT rc=%02h tx_valid=%0d", rc, tx_valid);

        // Interrupt request while idle with Pi data pending
        rx_valid = 1'b1;
        rx_data  = 8'h11;
        @(negedge r_clk);
        @(negedge r_clk);
`ifdef TIPI_EXTINT_EN
        check("extint_low", ti_extint_n, 1'b0);
`else
        check("extint_tied", ti_extint_n, 1'b1);
`endif
        rx_valid = 1'b0;
        $display("EXTINT rx_valid idle ti_extint_n=%0d", ti_extint_n);
        rx_byte(8'h11, 0);

        // Randomized traffic
        for (int it = 0; it < 60; it++) begin
            op = $urandom_range(0, 9);
            case (op)
                0, 1, 2, 3: send_msg($urandom_range(0, 5), 1000);
                4: begin
                    send_msg($urandom_range(1, 65535), $urandom_range(1, 2));
                    rx_byte(8'($urandom), $urandom_range(0, 4));
                end
                5, 6: rx_byte(8'($urandom), $urandom_range(0, 4));
                7: do_sync();
                default: begin
                    do c = 8'($urandom_range(8, 239)); while (c == m_last);
                    bad_code(c);
                end
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
